cnet_selectmap_rx: RTL

- Synthesizable slave end of the CNET SelectMAP configuration interface; the target-side counterpart of the CPCI reprogramming master.
- Used in CNET-side self-test and loopback builds:
  - receives the byte stream the master drives on rp_data under rp_cclk / rp_cs_b / rp_rdwr_b;
  - un-reverses and packs bytes into 32-bit words;
  - verifies a trailing additive check word;
  - reports status back on rp_init_b / rp_done exactly as a configuring FPGA would.

---
 rtl/cnet_selectmap_pkg.sv | 40 ++++
 rtl/cnet_selectmap_rx_sync.sv | 38 +++
 rtl/cnet_selectmap_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cnet_selectmap_pkg.sv
// CNET SelectMAP receive side: shared types and helpers.
// State encoding, pin bundle and byte bit-order helper.
package cnet_selectmap_pkg;

    localparam int SELECTMAP_BYTE_W = 8;
    localparam int WORD_W           = 32;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } sm_state_t;

    typedef struct packed {
        logic                        prog_b;
        logic                        cclk;
        logic                        cs_b;
        logic                        rdwr_b;
        logic [SELECTMAP_BYTE_W-1:0] data;
    } pins_t;

    // prog_b idles deasserted so the clear time starts at reset release
    localparam pins_t PINS_IDLE = '{
        prog_b: 1'b1,
        cclk:   1'b0,
        cs_b:   1'b1,
        rdwr_b: 1'b1,
        data:   '0
    };

    function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/cnet_selectmap_rx_sync.sv
// Two-flop synchronizer for every SelectMAP pin.
// All pins share one pipeline so data stays aligned with cclk.
module selectmap_pin_sync
    import cnet_selectmap_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        prog_b,
    input  logic                        cclk,
    input  logic                        cs_b,
    input  logic                        rdwr_b,
    input  logic [SELECTMAP_BYTE_W-1:0] data,
    output pins_t                       pins,
    output logic                        cclk_rise
);

    pins_t meta_q;
    pins_t sync_q;
    logic  cclk_prev_q;

    // Two-stage capture plus previous cclk for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q      <= PINS_IDLE;
            sync_q      <= PINS_IDLE;
            cclk_prev_q <= 1'b0;
        end else begin
            meta_q      <= '{prog_b: prog_b, cclk: cclk, cs_b: cs_b,
                             rdwr_b: rdwr_b, data: data};
            sync_q      <= meta_q;
            cclk_prev_q <= sync_q.cclk;
        end
    end

    assign pins      = sync_q;
    assign cclk_rise = sync_q.cclk && !cclk_prev_q;

endmodule

// File: rtl/cnet_selectmap_rx.sv
// SelectMAP configuration slave for CNET self-test builds.
// Packs bit-reversed bytes into words and verifies a sum word.
module cnet_selectmap_rx
    import cnet_selectmap_pkg::*;
#(
    parameter int NUM_WORDS    = 4,
    parameter int CLEAR_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        rp_prog_b,
    input  logic                        rp_cclk,
    input  logic                        rp_cs_b,
    input  logic                        rp_rdwr_b,
    input  logic [SELECTMAP_BYTE_W-1:0] rp_data,
    output logic                        rp_init_b,
    output logic                        rp_done,
    output logic [WORD_W-1:0]           word_data,
    output logic                        word_vld,
    input  logic                        word_rdy,
    output logic                        busy,
    output logic                        crc_err,
    output logic                        overflow
);

    localparam int CW  = $clog2(CLEAR_CYCLES + 1);
    localparam int WCW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CW-1:0]  CLR_LAST  = CW'(CLEAR_CYCLES - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(NUM_WORDS - 1);

    pins_t             pins;
    logic              cclk_rise;
    sm_state_t         state_q;
    sm_state_t         state_d;
    logic [CW-1:0]     clr_cnt_q;
    logic [1:0]        byte_idx_q;
    logic [WCW-1:0]    word_cnt_q;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] sum_q;
    logic              complete_q;
    logic              accept;
    logic              last_word;

    selectmap_pin_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .prog_b    (rp_prog_b),
        .cclk      (rp_cclk),
        .cs_b      (rp_cs_b),
        .rdwr_b    (rp_rdwr_b),
        .data      (rp_data),
        .pins      (pins),
        .cclk_rise (cclk_rise)
    );

    assign accept = (state_q == ST_LOAD) && cclk_rise
                    && !pins.cs_b && !pins.rdwr_b;
    assign last_word = (word_cnt_q == WORD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort wins, then clear timeout and word checks
    always_comb begin
        state_d = state_q;
        if (!pins.prog_b) begin
            state_d = ST_CLEAR;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (complete_q) begin
                        if (last_word) begin
                            state_d = (asm_q == sum_q) ? ST_DONE : ST_ERROR;
                        end else if (word_vld && !word_rdy) begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_DONE:  ;
                ST_ERROR: ;
            endcase
        end
    end

    // Status pins decoded from state, as a configuring FPGA reports them
    always_comb begin
        rp_init_b = 1'b0;
        rp_done   = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_CLEAR: busy = 1'b1;
            ST_LOAD: begin
                rp_init_b = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: begin
                rp_init_b = 1'b1;
                rp_done   = 1'b1;
            end
            ST_ERROR: ;
        endcase
    end

    // Clear timer, byte packing, word hand-off, running sum, sticky flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_cnt_q  <= '0;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            sum_q      <= '0;
            complete_q <= 1'b0;
            word_data  <= '0;
            word_vld   <= 1'b0;
            crc_err    <= 1'b0;
            overflow   <= 1'b0;
        end else if (!pins.prog_b || state_q == ST_CLEAR) begin
            clr_cnt_q  <= pins.prog_b ? clr_cnt_q + 1'b1 : '0;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            sum_q      <= '0;
            complete_q <= 1'b0;
            word_vld   <= 1'b0;
            crc_err    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            if (word_vld && word_rdy) begin
                word_vld <= 1'b0;
            end
            if (accept) begin
                asm_q[{byte_idx_q, 3'b000} +: 8] <= bit_reverse8(pins.data);
                byte_idx_q <= byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    complete_q <= 1'b1;
                end
            end
            if (complete_q && state_q == ST_LOAD) begin
                if (last_word) begin
                    if (asm_q != sum_q) begin
                        crc_err <= 1'b1;
                    end
                end else if (word_vld && !word_rdy) begin
                    overflow <= 1'b1;
                end else begin
                    word_data  <= asm_q;
                    word_vld   <= 1'b1;
                    sum_q      <= sum_q + asm_q;
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule
